nec_ir_rx: RTL and testbench

//  NEC infrared frame decoder for the demodulated receiver output (active-low marks, idle high).

---
 rtl/nec_ir_rx_if.sv | 12 +
 rtl/nec_ir_rx.sv | 177 +++++++++++++++++
 tb/tb_nec_ir_rx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nec_ir_rx_if.sv
// rtl/nec_ir_rx_if.sv - receiver input and decoded-frame outputs of the NEC IR decoder
interface nec_ir_rx_if;
    logic        IR;
    logic [31:0] data;
    logic        load;
    logic        rep;
    logic        err;
    logic [1:0]  state;

    modport master (input IR, output data, output load, output rep, output err, output state);
    modport slave  (output IR, input data, input load, input rep, input err, input state);
endinterface

// File: rtl/nec_ir_rx.sv
// rtl/nec_ir_rx.sv - NEC infrared frame decoder
// Times marks/spaces of the synchronized receiver line and publishes frames, repeats and errors.
module nec_ir_rx #(
    parameter int CNT_W      = 16,
    parameter int LEAD_MARK  = 9000,
    parameter int LEAD_SPACE = 4500,
    parameter int REP_SPACE  = 2250,
    parameter int BIT_MARK   = 560,
    parameter int ZERO_SPACE = 560,
    parameter int ONE_SPACE  = 1690,
    parameter int TOL_SHIFT  = 2,
    parameter int TIMEOUT    = 12000
) (
    input  logic          clk,
    input  logic          reset_n,
    nec_ir_rx_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LEAD  = 2'b01,
        S_DATA  = 2'b10,
        S_TRAIL = 2'b11
    } state_t;

    state_t             st;
    logic               ir_m, ir_s, ir_d;
    logic [CNT_W-1:0]   cnt;
    logic               in_space;
    logic               repflag;
    logic               have_frame;
    logic [4:0]         bit_cnt;
    logic [31:0]        shift;
    logic [31:0]        data_r;
    logic               load_r, rep_r, err_r;

    function automatic logic in_win(input logic [CNT_W-1:0] len, input int nom);
        logic [31:0] l, lo, hi;
        l  = 32'(len);
        lo = 32'(nom - (nom >> TOL_SHIFT));
        hi = 32'(nom + (nom >> TOL_SHIFT));
        return (l >= lo) && (l <= hi);
    endfunction

    logic fall, rise, edge_any, timeout;
    logic lead_mark_ok, lead_space_ok, rep_space_ok, bit_mark_ok, zero_ok, one_ok;

    assign fall          = ir_d & ~ir_s;
    assign rise          = ~ir_d & ir_s;
    assign edge_any      = fall | rise;
    assign timeout       = 32'(cnt) >= 32'(TIMEOUT);
    assign lead_mark_ok  = in_win(cnt, LEAD_MARK);
    assign lead_space_ok = in_win(cnt, LEAD_SPACE);
    assign rep_space_ok  = in_win(cnt, REP_SPACE);
    assign bit_mark_ok   = in_win(cnt, BIT_MARK);
    assign zero_ok       = in_win(cnt, ZERO_SPACE);
    assign one_ok        = in_win(cnt, ONE_SPACE);

    assign bus.data  = data_r;
    assign bus.load  = load_r;
    assign bus.rep   = rep_r;
    assign bus.err   = err_r;
    assign bus.state = st;

    always_ff @(posedge clk or negedge reset_n) begin
        logic bad;
        if (!reset_n) begin
            st         <= S_IDLE;
            ir_m       <= 1'b1;
            ir_s       <= 1'b1;
            ir_d       <= 1'b1;
            cnt        <= '0;
            in_space   <= 1'b0;
            repflag    <= 1'b0;
            have_frame <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_r     <= '0;
            load_r     <= 1'b0;
            rep_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            bad    = 1'b0;
            ir_m   <= bus.IR;
            ir_s   <= ir_m;
            ir_d   <= ir_s;
            load_r <= 1'b0;
            rep_r  <= 1'b0;
            err_r  <= 1'b0;

            if (edge_any)
                cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;

            case (st)
                S_IDLE: begin
                    // Rising edges here are leftovers of an aborted frame and are ignored.
                    if (fall) begin
                        st       <= S_LEAD;
                        in_space <= 1'b0;
                        repflag  <= 1'b0;
                    end
                end
                S_LEAD: begin
                    if (edge_any) begin
                        if (!in_space) begin
                            if (rise && lead_mark_ok) in_space <= 1'b1;
                            else                      bad = 1'b1;
                        end else if (fall && lead_space_ok) begin
                            bit_cnt  <= '0;
                            in_space <= 1'b0;
                            st       <= S_DATA;
                        end else if (fall && rep_space_ok) begin
                            repflag  <= 1'b1;
                            in_space <= 1'b0;
                            st       <= S_TRAIL;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (timeout) begin
                        bad = 1'b1;
                    end
                end
                S_DATA: begin
                    if (edge_any) begin
                        if (!in_space) begin
                            if (rise && bit_mark_ok) in_space <= 1'b1;
                            else                     bad = 1'b1;
                        end else if (fall && (zero_ok || one_ok)) begin
                            // Byte 0 lands in [31:24], each byte filled LSB first.
                            shift[{~bit_cnt[4:3], bit_cnt[2:0]}] <= one_ok;
                            in_space <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd31) st <= S_TRAIL;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (timeout) begin
                        bad = 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (edge_any) begin
                        if (rise && bit_mark_ok) begin
                            st      <= S_IDLE;
                            repflag <= 1'b0;
                            if (repflag) begin
                                if (have_frame) rep_r <= 1'b1;
                                else            err_r <= 1'b1;
                            end else if (shift[7:0] == ~shift[15:8]) begin
                                data_r     <= shift;
                                load_r     <= 1'b1;
                                have_frame <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (timeout) begin
                        bad = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase

            if (bad) begin
                err_r    <= 1'b1;
                st       <= S_IDLE;
                repflag  <= 1'b0;
                in_space <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_rx.sv
// tb/tb_nec_ir_rx.sv - self-checking bench for nec_ir_rx
module tb_nec_ir_rx;
    localparam int LM  = 450;
    localparam int LS  = 225;
    localparam int RS  = 112;
    localparam int BM  = 28;
    localparam int ZS  = 28;
    localparam int OS  = 84;
    localparam int TO  = 600;
    localparam int GAP = 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ir_line = 1'b1;

    nec_ir_rx_if bus();
    assign bus.IR = ir_line;

    nec_ir_rx #(
        .CNT_W(16), .LEAD_MARK(LM), .LEAD_SPACE(LS), .REP_SPACE(RS),
        .BIT_MARK(BM), .ZERO_SPACE(ZS), .ONE_SPACE(OS), .TOL_SHIFT(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int n_load = 0, n_rep = 0, n_err = 0, viol = 0, cyc = 0, err_cyc = 0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_st = '0;
    logic [1:0]  st_log[$];

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (bus.load) n_load++;
            if (bus.rep)  n_rep++;
            if (bus.err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (int'(bus.load) + int'(bus.rep) + int'(bus.err) > 1) viol++;
            if (bus.data !== prev_data && !bus.load) viol++;
            if (bus.state != prev_st) st_log.push_back(bus.state);
        end
        prev_data = bus.data;
        prev_st   = bus.state;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        ir_line = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int dur(input int n, input logic jit);
        int j;
        j = n >> 3;
        if (!jit) return n;
        return n - j + int'($urandom_range(32'(2 * j)));
    endfunction

    task automatic send_frame(input logic [31:0] w, input int lead, input logic lead_only,
                              input int nbits, input int bad_bit, input logic jit);
        int idx;
        seg(1'b0, lead);
        if (lead_only) begin
            seg(1'b1, GAP);
            return;
        end
        seg(1'b1, dur(LS, jit));
        for (int k = 0; k < nbits; k++) begin
            idx = 8 * (3 - k / 8) + k % 8;
            seg(1'b0, dur(BM, jit));
            if (k == bad_bit) begin
                seg(1'b1, 140);
                seg(1'b0, BM);
                seg(1'b1, GAP);
                return;
            end
            seg(1'b1, w[idx] ? dur(OS, jit) : dur(ZS, jit));
        end
        if (nbits == 32) begin
            seg(1'b0, dur(BM, jit));
            seg(1'b1, GAP);
        end
    endtask

    task automatic send_repeat(input logic jit);
        seg(1'b0, dur(LM, jit));
        seg(1'b1, dur(RS, jit));
        seg(1'b0, dur(BM, jit));
        seg(1'b1, GAP);
    endtask

    typedef struct {
        logic        is_rep;
        logic [31:0] word;
        int          lead;
        logic        lead_only;
        int          exp_load;
        int          exp_rep;
        int          exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[5];
    int l0, r0, e0, s0, t0;
    logic [31:0] seq;
    logic        have;
    logic [31:0] exp_data;
    logic [7:0]  a0, a1, cmd, inv;
    int          r, bad_bit, el, er, ee;

    initial begin
        tbl[0] = '{1'b0, 32'h00FF45BA, LM,  1'b0, 1, 0, 0, 32'h00FF45BA};
        tbl[1] = '{1'b1, 32'h0,        LM,  1'b0, 0, 1, 0, 32'h00FF45BA};
        tbl[2] = '{1'b0, 32'h00FF45BB, LM,  1'b0, 0, 0, 1, 32'h00FF45BA};
        tbl[3] = '{1'b0, 32'h0,        300, 1'b1, 0, 0, 1, 32'h00FF45BA};
        tbl[4] = '{1'b0, 32'h00FF16E9, LM,  1'b0, 1, 0, 0, 32'h00FF16E9};

        repeat (3) @(posedge clk);
        #1;
        check("reset data", bus.data, 32'h0);
        check("reset pulses", {29'b0, bus.load, bus.rep, bus.err}, 32'h0);
        check("reset state", {30'b0, bus.state}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            l0 = n_load; r0 = n_rep; e0 = n_err; s0 = st_log.size();
            if (tbl[i].is_rep) send_repeat(1'b0);
            else send_frame(tbl[i].word, tbl[i].lead, tbl[i].lead_only, 32, -1, 1'b0);
            check($sformatf("vec%0d load", i), 32'(n_load - l0), 32'(tbl[i].exp_load));
            check($sformatf("vec%0d rep", i),  32'(n_rep - r0),  32'(tbl[i].exp_rep));
            check($sformatf("vec%0d err", i),  32'(n_err - e0),  32'(tbl[i].exp_err));
            check($sformatf("vec%0d data", i), bus.data, tbl[i].exp_data);
            check($sformatf("vec%0d state", i), {30'b0, bus.state}, 32'h0);
            if (i == 0) begin
                seq = '0;
                for (int j = s0; j < st_log.size(); j++) seq = (seq << 2) | {30'b0, st_log[j]};
                check("vec0 state sequence", seq, 32'h6C);
            end
        end

        have = 1'b1;
        exp_data = 32'h00FF16E9;
        for (int i = 0; i < 6; i++) begin
            l0 = n_load; r0 = n_rep; e0 = n_err;
            r = int'($urandom_range(9));
            el = 0; er = 0; ee = 0;
            if (r < 2) begin
                send_repeat(1'b1);
                if (have) er = 1; else ee = 1;
            end else begin
                a0  = 8'($urandom);
                a1  = 8'($urandom);
                cmd = 8'($urandom);
                inv = ~cmd;
                if (r < 4) inv = inv ^ 8'($urandom_range(1, 255));
                bad_bit = (r == 9) ? int'($urandom_range(31)) : -1;
                send_frame({a0, a1, cmd, inv}, dur(LM, 1'b1), 1'b0, 32, bad_bit, 1'b1);
                if (bad_bit >= 0) ee = 1;
                else if (inv == ~cmd) begin
                    el = 1;
                    exp_data = {a0, a1, cmd, inv};
                    have = 1'b1;
                end else ee = 1;
            end
            check($sformatf("rnd%0d load", i), 32'(n_load - l0), 32'(el));
            check($sformatf("rnd%0d rep", i),  32'(n_rep - r0),  32'(er));
            check($sformatf("rnd%0d err", i),  32'(n_err - e0),  32'(ee));
            check($sformatf("rnd%0d data", i), bus.data, exp_data);
        end

        send_frame(32'h00FF45BA, LM, 1'b0, 17, -1, 1'b0);
        ir_line = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("midframe state", {30'b0, bus.state}, 32'h2);
        reset_n = 1'b0;
        #1;
        check("async reset data", bus.data, 32'h0);
        check("async reset pulses", {29'b0, bus.load, bus.rep, bus.err}, 32'h0);
        check("async reset state", {30'b0, bus.state}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        ir_line = 1'b1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        l0 = n_load;
        send_frame(32'h00FF45BA, LM, 1'b0, 32, -1, 1'b0);
        check("post reset load", 32'(n_load - l0), 32'h1);
        check("post reset data", bus.data, 32'h00FF45BA);

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        r0 = n_rep; e0 = n_err;
        send_repeat(1'b0);
        check("orphan repeat rep", 32'(n_rep - r0), 32'h0);
        check("orphan repeat err", 32'(n_err - e0), 32'h1);

        e0 = n_err;
        seg(1'b0, LM);
        seg(1'b1, LS);
        ir_line = 1'b0;
        t0 = cyc;
        repeat (TO - 20) @(posedge clk);
        #1;
        check("timeout pre state", {30'b0, bus.state}, 32'h2);
        repeat (1000 - (TO - 20)) @(posedge clk);
        #1;
        seg(1'b1, GAP);
        check("timeout err count", 32'(n_err - e0), 32'h1);
        check("timeout err time", {31'b0, (err_cyc >= t0 + TO) && (err_cyc <= t0 + TO + 10)}, 32'h1);
        check("timeout end state", {30'b0, bus.state}, 32'h0);

        check("monitor violations", 32'(viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
